shared_dram: RTL

Parametrised, multi-port successor to the single-port data memory. One synchronous RAM array is shared by `NUM_CORES` requesters (cores or core-side caches) through a round-robin arbiter and a req/ack handshake. The block sits between the core array and main storage. It serialises all accesses, so exactly one read or write reaches the array per cycle.

---
 rtl/shared_dram_if.sv | 27 ++
 rtl/shared_dram.sv | 91 +++++++++
 2 files changed

// File: rtl/shared_dram_if.sv
// Requester-side bus of the shared data memory: one req/ack channel per port,
// with per-port fields flattened into packed vectors.
interface shared_dram_if #(
  parameter int NUM_CORES = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16
);
  // Handshake: a requester raises core_req[i] and holds core_we/core_addr/core_wdata
  // stable until core_ack[i] pulses for one cycle. req still high in the cycle after
  // the ack is a new request; a port is never granted in its own ack cycle.
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_ack;
  logic [NUM_CORES*DATA_W-1:0] core_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_ack, core_rdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_ack, core_rdata
  );
endinterface

// File: rtl/shared_dram.sv
// Single-port RAM shared by NUM_CORES requesters through a round-robin arbiter;
// exactly one access reaches the array per cycle.
module shared_dram #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 65536,
  parameter int NUM_CORES = 2
) (
  input  logic         clk,
  input  logic         rst,
  shared_dram_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LG_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [LG_W-1:0] LAST_PORT = LG_W'(NUM_CORES - 1);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]    rdata_q [NUM_CORES];
  logic [NUM_CORES-1:0] ack_q;
  logic [NUM_CORES-1:0] eligible;
  logic [LG_W-1:0]      last_grant_q;
  logic [LG_W-1:0]      gnt_idx;
  logic                 gnt_valid;

  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_in_range;
  logic [IDX_W-1:0]     sel_idx;
  logic [DATA_W-1:0]    rd_word;

  // A port in its ack cycle is dropping or replacing its request, so skip it.
  assign eligible = bus.core_req & ~ack_q;

  always_comb begin : arbiter
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_CORES;
      if (!gnt_valid && !rst && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = LG_W'(cand);
      end
    end
  end

  always_comb begin : select
    sel_we       = bus.core_we[gnt_idx];
    sel_addr     = bus.core_addr[gnt_idx*ADDR_W +: ADDR_W];
    sel_wdata    = bus.core_wdata[gnt_idx*DATA_W +: DATA_W];
    sel_in_range = 33'(sel_addr) < 33'(DEPTH);
    sel_idx      = sel_addr[IDX_W-1:0];
    rd_word      = sel_in_range ? mem[sel_idx] : '0;
  end

  // Array has no reset; gnt_valid is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (gnt_valid && sel_we && sel_in_range) begin
      mem[sel_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q        <= '0;
      last_grant_q <= LAST_PORT;
      for (int i = 0; i < NUM_CORES; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      ack_q <= '0;
      if (gnt_valid) begin
        ack_q[gnt_idx] <= 1'b1;
        last_grant_q   <= gnt_idx;
        if (!sel_we) begin
          rdata_q[gnt_idx] <= rd_word;
        end
      end
    end
  end

  assign bus.core_ack = ack_q;

  for (genvar p = 0; p < NUM_CORES; p++) begin : g_rdata
    assign bus.core_rdata[p*DATA_W +: DATA_W] = rdata_q[p];
  end

endmodule
